// File: rtl/nms_stream.sv
// nms_stream: streaming 3x3 non-maximum suppression over a raster score image,
// emitting surviving corner addresses and scores through a ready/valid port.
module nms_stream #(
    parameter int IMG_W   = 180,
    parameter int IMG_H   = 180,
    parameter int SCORE_W = 8,
    parameter int ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               strict,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SCORE_W-1:0] s_score,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [SCORE_W-1:0] m_score,
    output logic               busy,
    output logic               frame_done,
    output logic [ADDR_W-1:0]  corner_cnt
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

    stateT state, nextState;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [ADDR_W-1:0] pixAddr;
    logic strictQ;
    logic [SCORE_W-1:0] lineA [IMG_W];
    logic [SCORE_W-1:0] lineB [IMG_W];
    logic [SCORE_W-1:0] win [3][2];
    logic [SCORE_W-1:0] nb [3][3];
    logic xfer, colLast, lastPix, isPeak, emit;

    assign s_ready    = (state == RUN) && (!m_valid || m_ready);
    assign xfer       = s_valid && s_ready;
    assign colLast    = col == CW'(IMG_W - 1);
    assign lastPix    = colLast && row == RW'(IMG_H - 1);
    assign busy       = (state == RUN) || (state == DRAIN);
    assign frame_done = state == DONE;

    // The stored window holds the two older columns; the incoming pixel and
    // the line buffers at this column supply the newest one, so the centre is
    // judged in the same cycle its right-bottom neighbour arrives.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nb[i][0] = win[i][0];
            nb[i][1] = win[i][1];
        end
        nb[0][2] = lineB[col];
        nb[1][2] = lineA[col];
        nb[2][2] = s_score;
        isPeak = nb[1][1] != '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (!(i == 1 && j == 1))
                    isPeak = isPeak && (strictQ ? nb[1][1] > nb[i][j] : nb[1][1] >= nb[i][j]);
    end

    assign emit = xfer && row >= RW'(2) && col >= CW'(2) && isPeak;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  nextState = start ? RUN : IDLE;
            RUN:   nextState = (xfer && lastPix) ? DRAIN : RUN;
            DRAIN: nextState = m_valid ? DRAIN : DONE;
            DONE:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            pixAddr    <= '0;
            strictQ    <= 1'b0;
            m_valid    <= 1'b0;
            m_addr     <= '0;
            m_score    <= '0;
            corner_cnt <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && start) begin
                row        <= '0;
                col        <= '0;
                pixAddr    <= '0;
                corner_cnt <= '0;
                strictQ    <= strict;
            end else begin
                if (xfer) begin
                    col     <= colLast ? '0 : col + 1'b1;
                    row     <= colLast ? row + 1'b1 : row;
                    pixAddr <= pixAddr + 1'b1;
                end
                if (m_valid && m_ready && corner_cnt != '1)
                    corner_cnt <= corner_cnt + 1'b1;
            end
            if (emit) begin
                m_valid <= 1'b1;
                m_addr  <= pixAddr - ADDR_W'(IMG_W + 1);
                m_score <= nb[1][1];
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Line buffers and window are never reset; the row/col guard keeps stale data out.
    always_ff @(posedge clk) begin
        if (xfer) begin
            lineB[col] <= lineA[col];
            lineA[col] <= s_score;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= nb[i][2];
            end
        end
    end
endmodule

// File: tb/tb_nms_stream.sv
// tb_nms_stream: randomized frames against an image-level NMS model of nms_stream.
module tb_nms_stream;
    localparam int W = 8, H = 6, N = W * H;

    logic clk, rst_n, start, strict, s_valid, s_ready, m_valid, m_ready, busy, frame_done;
    logic [7:0] s_score, m_score;
    logic [14:0] m_addr, corner_cnt;

    nms_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .strict(strict),
        .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_score(m_score),
        .busy(busy), .frame_done(frame_done), .corner_cnt(corner_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int img [N];
    int expA [$];
    int expS [$];
    int expCount, doneCnt, holdAddr;
    bit holdValid;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit peakAt(int r, int c, bit st);
        int v = img[r * W + c];
        if (v == 0) return 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                int n;
                if (dr == 0 && dc == 0) continue;
                n = img[(r + dr) * W + c + dc];
                if (st ? v <= n : v < n) return 0;
            end
        return 1;
    endfunction

    task automatic buildExp(bit st);
        expA.delete();
        expS.delete();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                if (peakAt(r, c, st)) begin
                    expA.push_back(r * W + c);
                    expS.push_back(img[r * W + c]);
                end
        expCount = expA.size();
    endtask

    task automatic fill(int v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic fillRand(int hi);
        for (int i = 0; i < N; i++) img[i] = $urandom_range(0, hi);
    endtask

    always @(negedge clk) begin
        if (!rst_n) holdValid = 0;
        else begin
            if (holdValid) begin
                chk("hold valid", m_valid, 1);
                chk("hold addr", m_addr, holdAddr);
            end
            if (m_valid && m_ready) begin
                if (expA.size() == 0) chk("extra corner addr", m_addr, -1);
                else begin
                    chk("corner addr", m_addr, expA.pop_front());
                    chk("corner score", m_score, expS.pop_front());
                end
                holdValid = 0;
            end else begin
                holdValid = m_valid;
                holdAddr = m_addr;
            end
            if (frame_done) doneCnt++;
        end
    end

    // mode 0: random ready and stray start pulses, 1: ready always, 2: one 5-cycle stall
    task automatic runFrame(bit st, int mode, int abortAt);
        int p = 0, cyc = 0, bpLeft = 0;
        bit bpDone = 0, took;
        buildExp(st);
        doneCnt = 0;
        @(posedge clk); #1;
        strict = st;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        strict = !st;
        while (p < N && cyc < 3000) begin
            if (abortAt > 0 && p == abortAt) break;
            s_valid = ($urandom % 4) != 0;
            s_score = 8'(img[p]);
            if (mode == 2) begin
                if (m_valid && !bpDone) begin
                    bpLeft = 5;
                    bpDone = 1;
                end
                m_ready = bpLeft == 0;
            end else m_ready = mode == 1 || ($urandom % 3) != 0;
            start = mode == 0 && ($urandom % 8) == 0;
            @(negedge clk);
            took = s_valid && s_ready;
            if (bpLeft > 0) begin
                chk("bp s_ready", s_ready, 0);
                bpLeft--;
            end
            @(posedge clk); #1;
            if (took) p++;
            cyc++;
        end
        start = 0;
        s_valid = 0;
        m_ready = 1;
        if (abortAt > 0) return;
        chk("frame accepted", p, N);
        cyc = 0;
        while (!frame_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("frame_done seen", frame_done, 1);
        chk("corner_cnt", corner_cnt, expCount);
        chk("queue drained", expA.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done pulses", doneCnt, 1);
        chk("idle busy", busy, 0);
        if (mode == 2) chk("bp exercised", bpDone, 1);
    endtask

    task automatic chkZero(string tag);
        chk({tag, " m_valid"}, m_valid, 0);
        chk({tag, " s_ready"}, s_ready, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        chk({tag, " m_addr"}, m_addr, 0);
        chk({tag, " m_score"}, m_score, 0);
        chk({tag, " corner_cnt"}, corner_cnt, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; strict = 0; s_valid = 0; s_score = 0; m_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chkZero("reset");
        rst_n = 1;

        fill(0);
        runFrame(0, 1, 0);
        chk("zero frame cnt", corner_cnt, 0);

        fill(10); img[19] = 50;
        buildExp(1);
        chk("model peak count", expA.size(), 1);
        chk("model peak addr", expA[0], 19);
        runFrame(1, 0, 0);
        chk("peak cnt literal", corner_cnt, 1);

        fill(0); img[19] = 50; img[20] = 50;
        buildExp(0);
        chk("model tie count", expA.size(), 2);
        chk("model tie addr", expA[1], 20);
        runFrame(0, 0, 0);
        chk("tie nonstrict cnt", corner_cnt, 2);
        fill(10); img[19] = 50; img[20] = 50;
        runFrame(1, 0, 0);
        chk("tie strict cnt", corner_cnt, 0);

        fill(0); img[0] = 99; img[N - 1] = 99;
        runFrame(0, 1, 0);
        chk("border cnt", corner_cnt, 0);

        fill(10); img[19] = 50;
        runFrame(1, 2, 0);
        chk("bp cnt", corner_cnt, 1);

        for (int k = 0; k < 6; k++) begin
            fillRand(k < 4 ? 3 : 255);
            runFrame(k % 2 == 1, 0, 0);
        end

        fillRand(3);
        runFrame(0, 1, 20);
        rst_n = 0;
        #1;
        chkZero("midreset");
        @(posedge clk); #1;
        rst_n = 1;
        fillRand(3);
        runFrame(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
